// File: rtl/decode_stage.sv
// decode_stage: RV64 subset decode / operand fetch with per-register write scoreboard.
// Optional BYPASS_EN: forward same-cycle writeback data into captured operands.
module decode_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned SB_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic            wb_regWrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_aluCtrl,
  output logic [2:0]      out_funct3,
  output logic            out_regWrite,
  output logic            out_memRead,
  output logic            out_memWrite,
  output logic            out_branch,
  output logic            out_aluSrc,
  output logic            out_illegal
);

  typedef enum logic [6:0] {
    OPC_R  = 7'b0110011,
    OPC_I  = 7'b0010011,
    OPC_LD = 7'b0000011,
    OPC_SD = 7'b0100011,
    OPC_BR = 7'b1100011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    alu_e            alu;
    logic [2:0]      funct3;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    logic            branch;
    logic            aluSrc;
    logic            illegal;
  } bundle_t;

  localparam logic [SB_W-1:0] SB_MAX  = '1;
  localparam logic [SB_W-1:0] SB_NEAR = SB_MAX - SB_W'(1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f;
  logic [4:0] rs1_w;
  logic [4:0] rs2_w;

  logic            dec_legal;
  logic            dec_wr;
  logic            dec_mr;
  logic            dec_mw;
  logic            dec_br;
  logic            dec_src;
  logic            dec_use1;
  logic            dec_use2;
  alu_e            dec_alu;
  logic [XLEN-1:0] dec_imm;

  logic byp1;
  logic byp2;
  logic busy1;
  logic busy2;
  logic haz1;
  logic haz2;
  logic pend_v;
  logic ovf_stall;
  logic in_fire;
  logic out_fire;

  logic    valid_q;
  logic    valid_d;
  bundle_t bundle_q;
  bundle_t bundle_d;

  logic [SB_W-1:0] cnt_q [32];
  logic [SB_W-1:0] cnt_d [32];

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd_f   = in_instr[11:7];
  assign rs1_w  = in_instr[19:15];
  assign rs2_w  = in_instr[24:20];
  assign rs1    = rs1_w;
  assign rs2    = rs2_w;

  always_comb begin
    dec_legal = 1'b0;
    dec_wr    = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_br    = 1'b0;
    dec_src   = 1'b0;
    dec_use1  = 1'b0;
    dec_use2  = 1'b0;
    dec_alu   = ALU_ADD;
    dec_imm   = '0;
    case (opcode)
      OPC_R: begin
        dec_use1 = 1'b1;
        dec_use2 = 1'b1;
        dec_wr   = 1'b1;
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_alu   = ALU_ADD;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          dec_legal = 1'b1;
          dec_alu   = ALU_SUB;
        end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_alu   = ALU_AND;
        end else if (funct3 == 3'b110 && funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_alu   = ALU_OR;
        end
      end
      OPC_I: begin
        dec_use1 = 1'b1;
        dec_wr   = 1'b1;
        dec_src  = 1'b1;
        dec_imm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        case (funct3)
          3'b000:  begin dec_legal = 1'b1; dec_alu = ALU_ADD; end
          3'b111:  begin dec_legal = 1'b1; dec_alu = ALU_AND; end
          3'b110:  begin dec_legal = 1'b1; dec_alu = ALU_OR;  end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LD: begin
        dec_use1  = 1'b1;
        dec_wr    = 1'b1;
        dec_mr    = 1'b1;
        dec_src   = 1'b1;
        dec_alu   = ALU_ADD;
        dec_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        dec_legal = (funct3 != 3'b111);
      end
      OPC_SD: begin
        dec_use1  = 1'b1;
        dec_use2  = 1'b1;
        dec_mw    = 1'b1;
        dec_src   = 1'b1;
        dec_alu   = ALU_ADD;
        dec_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_legal = !funct3[2];
      end
      OPC_BR: begin
        dec_use1  = 1'b1;
        dec_use2  = 1'b1;
        dec_br    = 1'b1;
        dec_alu   = ALU_SUB;
        dec_imm   = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        dec_legal = (funct3[2:1] != 2'b01);
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_wr   = 1'b0;
      dec_mr   = 1'b0;
      dec_mw   = 1'b0;
      dec_br   = 1'b0;
      dec_src  = 1'b0;
      dec_use1 = 1'b0;
      dec_use2 = 1'b0;
      dec_alu  = ALU_AND;
      dec_imm  = '0;
    end
    if (rd_f == 5'd0) dec_wr = 1'b0;
  end

`ifdef BYPASS_EN
  assign byp1 = wb_regWrite && (wb_rd == rs1_w) && (rs1_w != 5'd0);
  assign byp2 = wb_regWrite && (wb_rd == rs2_w) && (rs2_w != 5'd0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign pend_v = valid_q && bundle_q.regWrite;
  assign busy1  = byp1 ? (cnt_q[rs1_w] > SB_W'(1)) : (cnt_q[rs1_w] != '0);
  assign busy2  = byp2 ? (cnt_q[rs2_w] > SB_W'(1)) : (cnt_q[rs2_w] != '0);
  assign haz1   = (rs1_w != 5'd0) && dec_use1 &&
                  ((pend_v && bundle_q.rd == rs1_w) || busy1);
  assign haz2   = (rs2_w != 5'd0) && dec_use2 &&
                  ((pend_v && bundle_q.rd == rs2_w) || busy2);
  // The held bundle is not yet counted, so it is included to keep the counter from wrapping.
  assign ovf_stall = dec_wr && ((cnt_q[rd_f] == SB_MAX) ||
                     (pend_v && bundle_q.rd == rd_f && cnt_q[rd_f] == SB_NEAR));

  assign in_ready = (!valid_q || out_ready) && !haz1 && !haz2 && !ovf_stall && !flush;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = valid_q && out_ready && !flush;

  always_comb begin
    bundle_d          = bundle_q;
    valid_d           = valid_q;
    if (in_fire) begin
      valid_d           = 1'b1;
      bundle_d.pc       = in_pc;
      bundle_d.op1      = (rs1_w == 5'd0 || !dec_use1) ? '0 : (byp1 ? wb_data : ReadData1);
      bundle_d.op2      = (rs2_w == 5'd0 || !dec_use2) ? '0 : (byp2 ? wb_data : ReadData2);
      bundle_d.imm      = dec_imm;
      bundle_d.rd       = rd_f;
      bundle_d.alu      = dec_alu;
      bundle_d.funct3   = funct3;
      bundle_d.regWrite = dec_wr;
      bundle_d.memRead  = dec_mr;
      bundle_d.memWrite = dec_mw;
      bundle_d.branch   = dec_br;
      bundle_d.aluSrc   = dec_src;
      bundle_d.illegal  = !dec_legal;
    end else if (valid_q && (out_ready || flush)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if ((out_fire && bundle_q.regWrite && bundle_q.rd == 5'(r)) &&
          !(wb_regWrite && wb_rd == 5'(r) && r != 0)) begin
        cnt_d[r] = cnt_q[r] + SB_W'(1);
      end else if (!(out_fire && bundle_q.regWrite && bundle_q.rd == 5'(r)) &&
                   (wb_regWrite && wb_rd == 5'(r) && r != 0) && cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - SB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = bundle_q.pc;
  assign out_op1      = bundle_q.op1;
  assign out_op2      = bundle_q.op2;
  assign out_imm      = bundle_q.imm;
  assign out_rd       = bundle_q.rd;
  assign out_aluCtrl  = bundle_q.alu;
  assign out_funct3   = bundle_q.funct3;
  assign out_regWrite = bundle_q.regWrite;
  assign out_memRead  = bundle_q.memRead;
  assign out_memWrite = bundle_q.memWrite;
  assign out_branch   = bundle_q.branch;
  assign out_aluSrc   = bundle_q.aluSrc;
  assign out_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; honours BYPASS_EN for the RAW forwarding case.
module tb_decode_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] ReadData1;
  logic [XLEN-1:0] ReadData2;
  logic            wb_regWrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic [3:0]      out_aluCtrl;
  logic [2:0]      out_funct3;
  logic            out_regWrite;
  logic            out_memRead;
  logic            out_memWrite;
  logic            out_branch;
  logic            out_aluSrc;
  logic            out_illegal;

  decode_stage #(.XLEN(64), .SB_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1(rs1), .rs2(rs2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_rd(out_rd),
    .out_aluCtrl(out_aluCtrl), .out_funct3(out_funct3),
    .out_regWrite(out_regWrite), .out_memRead(out_memRead), .out_memWrite(out_memWrite),
    .out_branch(out_branch), .out_aluSrc(out_aluSrc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [2:0] f3,
                                         input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d,
                                         input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [2:0] f3);
    return {imm[11:5], s2, s1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [2:0] f3);
    return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [63:0] imm;
    logic        imm_chk;
    logic [2:0]  f3;
    logic [5:0]  flags;   // {regWrite, memRead, memWrite, branch, aluSrc, illegal}
  } vec_t;

  vec_t vt [9];

  initial begin
    vt[0] = '{r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd11), 4'b0110, 64'd0, 1'b0, 3'd0, 6'b100000};
    vt[1] = '{r_type(7'h00, 5'd2, 5'd1, 3'b110, 5'd12), 4'b0001, 64'd0, 1'b0, 3'd6, 6'b100000};
    vt[2] = '{r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd13), 4'b0000, 64'd0, 1'b0, 3'd7, 6'b100000};
    vt[3] = '{i_type(12'hFFF, 5'd2, 3'b011, 5'd4, 7'b0000011), 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd3, 6'b110010};
    vt[4] = '{b_type(13'd16, 5'd2, 5'd1, 3'b000), 4'b0110, 64'd16, 1'b1, 3'd0, 6'b000100};
    vt[5] = '{b_type(13'h1FF8, 5'd2, 5'd1, 3'b001), 4'b0110, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 3'd1, 6'b000100};
    vt[6] = '{r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 4'b0010, 64'd0, 1'b0, 3'd0, 6'b000000};
    vt[7] = '{i_type(12'hFFF, 5'd1, 3'b111, 5'd14, 7'b0010011), 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd7, 6'b100010};
    vt[8] = '{i_type(12'h7FF, 5'd1, 3'b110, 5'd15, 7'b0010011), 4'b0001, 64'h7FF, 1'b1, 3'd6, 6'b100010};
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    ReadData1 = '0; ReadData2 = '0; wb_regWrite = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    tick; tick;
    check("rst_valid", out_valid, 0);
    check("rst_op1", out_op1, 0);
    reset = 1'b0;

    // store: operands, S immediate, control
    in_valid = 1'b1; in_instr = s_type(12'd8, 5'd10, 5'd21, 3'b011); in_pc = 64'h100;
    ReadData1 = 64'd4; ReadData2 = 64'd15; out_ready = 1'b0;
    #1;
    check("sd_rs1", rs1, 21);
    check("sd_rs2", rs2, 10);
    check("sd_ready", in_ready, 1);
    tick;
    in_valid = 1'b0; ReadData1 = 64'hDEAD; ReadData2 = 64'hBEEF;
    check("sd_valid", out_valid, 1);
    check("sd_op1", out_op1, 4);
    check("sd_op2", out_op2, 15);
    check("sd_imm", out_imm, 8);
    check("sd_memw", out_memWrite, 1);
    check("sd_regw", out_regWrite, 0);
    check("sd_alu", out_aluCtrl, 4'b0010);
    check("sd_src", out_aluSrc, 1);
    check("sd_f3", out_funct3, 3);
    check("sd_pc", out_pc, 64'h100);

    // downstream backpressure for three cycles
    in_valid = 1'b1; in_instr = i_type(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011); in_pc = 64'h104;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", in_ready, 0);
      check("bp_op1", out_op1, 4);
      check("bp_pc", out_pc, 64'h100);
      tick;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 1);
    tick;
    in_valid = 1'b0;
    check("bp_next_pc", out_pc, 64'h104);
    check("bp_next_rd", out_rd, 1);
    check("bp_next_regw", out_regWrite, 1);
    check("bp_next_imm", out_imm, 3);
    tick;
    check("bp_drain", out_valid, 0);
    wb_regWrite = 1'b1; wb_rd = 5'd1; wb_data = 64'd3;
    tick;
    wb_regWrite = 1'b0;

    // RAW: addi x5,x0,7 ; add x6,x5,x5
    in_valid = 1'b1; in_instr = i_type(12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011); in_pc = 64'h300;
    #1;
    check("raw_first", in_ready, 1);
    tick;
    in_instr = r_type(7'h00, 5'd5, 5'd5, 3'b000, 5'd6); in_pc = 64'h304;
    #1;
    check("raw_pend", in_ready, 0);
    check("raw_imm", out_imm, 7);
    tick;
    check("raw_gap", out_valid, 0);
    wb_regWrite = 1'b1; wb_rd = 5'd5; wb_data = 64'd7; ReadData1 = 64'h99; ReadData2 = 64'h99;
`ifdef BYPASS_EN
    #1;
    check("raw_byp", in_ready, 1);
    tick;
    wb_regWrite = 1'b0; in_valid = 1'b0;
`else
    #1;
    check("raw_busy", in_ready, 0);
    tick;
    wb_regWrite = 1'b0; ReadData1 = 64'd7; ReadData2 = 64'd7;
    #1;
    check("raw_rf", in_ready, 1);
    tick;
    in_valid = 1'b0;
`endif
    check("raw_valid", out_valid, 1);
    check("raw_op1", out_op1, 7);
    check("raw_op2", out_op2, 7);
    check("raw_rd", out_rd, 6);
    check("raw_pc", out_pc, 64'h304);
    tick;
    wb_regWrite = 1'b1; wb_rd = 5'd6; wb_data = 64'd14;
    tick;
    wb_regWrite = 1'b0;

    // flush drops a held x7 writer without scoreboarding it
    in_valid = 1'b1; in_instr = i_type(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011); in_pc = 64'h400;
    out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    check("fl_held", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    check("fl_ready", in_ready, 0);
    tick;
    flush = 1'b0;
    check("fl_drop", out_valid, 0);
    in_valid = 1'b1; in_instr = r_type(7'h00, 5'd7, 5'd7, 3'b000, 5'd8); in_pc = 64'h404;
    #1;
    check("fl_nostall", in_ready, 1);
    tick;
    in_valid = 1'b0;
    check("fl_next_valid", out_valid, 1);
    check("fl_next_pc", out_pc, 64'h404);
    tick;

    // decode table
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_instr = vt[i].instr; in_pc = 64'h200 + 64'(4 * i);
      tick;
      in_valid = 1'b0;
      check("dec_valid", out_valid, 1);
      check("dec_alu", out_aluCtrl, vt[i].alu);
      check("dec_f3", out_funct3, vt[i].f3);
      check("dec_flags", {out_regWrite, out_memRead, out_memWrite, out_branch, out_aluSrc, out_illegal},
            vt[i].flags);
      if (vt[i].imm_chk) check("dec_imm", out_imm, vt[i].imm);
    end
    tick;

    // illegal encodings
    in_valid = 1'b1; in_instr = 32'h0000037F;
    tick;
    in_valid = 1'b0;
    check("ill_opc_valid", out_valid, 1);
    check("ill_opc_flags", {out_regWrite, out_memRead, out_memWrite, out_branch, out_illegal}, 5'b00001);
    in_valid = 1'b1; in_instr = r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd3);
    tick;
    in_valid = 1'b0;
    check("ill_f7_flags", {out_regWrite, out_memRead, out_memWrite, out_branch, out_illegal}, 5'b00001);
    tick;

    // async reset with a held bundle and cnt[5]=2
    in_valid = 1'b1; in_instr = i_type(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011); in_pc = 64'h500;
    tick; tick; tick;
    out_ready = 1'b0; in_valid = 1'b0;
    check("ar_pre_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_pc", out_pc, 0);
    check("ar_rd", out_rd, 0);
    check("ar_imm", out_imm, 0);
    check("ar_regw", out_regWrite, 0);
    #1;
    reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = r_type(7'h00, 5'd5, 5'd5, 3'b000, 5'd16);
    in_pc = 64'h600;
    #1;
    check("ar_cnt_clear", in_ready, 1);
    tick;
    in_valid = 1'b0;
    check("ar_accept", out_valid, 1);
    tick;

    // scoreboard saturation on x9
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_instr = i_type(12'd1, 5'd0, 3'b000, 5'd9, 7'b0010011);
      tick;
      in_valid = 1'b0;
      tick;
    end
    in_valid = 1'b1; in_instr = i_type(12'd2, 5'd0, 3'b000, 5'd9, 7'b0010011); in_pc = 64'h700;
    #1;
    check("ovf_stall", in_ready, 0);
    tick;
    check("ovf_stall2", in_ready, 0);
    wb_regWrite = 1'b1; wb_rd = 5'd9; wb_data = 64'd1;
    #1;
    check("ovf_wb_same", in_ready, 0);
    tick;
    wb_regWrite = 1'b0;
    #1;
    check("ovf_release", in_ready, 1);
    tick;
    in_valid = 1'b0;
    check("ovf_valid", out_valid, 1);
    check("ovf_rd", out_rd, 9);
    check("ovf_imm", out_imm, 2);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
